// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic MIPS pipeline boundary register (F/D, D/E, E/M, M/W). Carries the
//   instruction, PC+8, branch-delay-slot flag and exception code together
//   with a valid bit. Each clock edge resolves one action in fixed priority:
//   rst > flush > stall (en=0) > bubble (clr) > load.
//   Three saturating counters record stalls, bubbles and flushes so the
//   hazard unit's behaviour can be measured.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   en         in   1        stage enable; 0 = stall (hold contents)
//   clr        in   1        insert bubble (honoured only when en=1)
//   flush      in   1        exception flush; overrides stall
//   instr_i    in   INSTR_W  incoming instruction
//   pc_i       in   PC_W     incoming PC+8
//   bd_i       in   1        incoming instruction is in a branch delay slot
//   exc_vld_i  in   1        incoming instruction carries an exception
//   exc_i      in   EXC_W    incoming exception code
//   instr_o    out  INSTR_W  registered instruction
//   imm_o      out  16       low 16 bits of the instruction register
//   pc_o       out  PC_W     registered PC+8
//   bd_o       out  1        registered delay-slot flag
//   valid_o    out  1        1 = real instruction, 0 = bubble
//   exc_vld_o  out  1        registered exception flag
//   exc_o      out  EXC_W    registered exception code (0 when no exception)
//   stall_cnt  out  CNT_W    cycles a valid instruction was held by en=0
//   bubble_cnt out  CNT_W    bubbles inserted via clr
//   flush_cnt  out  CNT_W    flush events applied
module pipe_stage_reg #(
  parameter int                 INSTR_W = 32,
  parameter int                 PC_W    = 32,
  parameter int                 EXC_W   = 5,
  parameter logic [INSTR_W-1:0] NOP_VAL = '0,
  parameter bit                 KEEP_PC = 1'b1,
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               bd_i,
  input  logic               exc_vld_i,
  input  logic [EXC_W-1:0]   exc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [15:0]        imm_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               bd_o,
  output logic               valid_o,
  output logic               exc_vld_o,
  output logic [EXC_W-1:0]   exc_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Saturating increment: stays at all-ones once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               bd_p1;
  logic               vld_p1;
  logic               exc_vld_p1;
  logic [EXC_W-1:0]   exc_p1;
  logic [CNT_W-1:0]   stall_cnt_p1;
  logic [CNT_W-1:0]   bubble_cnt_p1;
  logic [CNT_W-1:0]   flush_cnt_p1;

  // A bubble and a flush write identical register contents; only the
  // counter that is bumped differs.
  logic kill;
  assign kill = flush | (en & clr);

  // Stage boundary: inputs -> registered outputs (one cycle latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1      <= '0;
      pc_p1         <= '0;
      bd_p1         <= 1'b0;
      vld_p1        <= 1'b0;
      exc_vld_p1    <= 1'b0;
      exc_p1        <= '0;
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
      flush_cnt_p1  <= '0;
    end else if (kill) begin
      instr_p1   <= NOP_VAL;
      vld_p1     <= 1'b0;
      exc_vld_p1 <= 1'b0;
      exc_p1     <= '0;
      // KEEP_PC lets a squashed slot still carry its PC for EPC tracking.
      pc_p1      <= KEEP_PC ? pc_i : '0;
      bd_p1      <= KEEP_PC ? bd_i : 1'b0;
      if (flush) flush_cnt_p1  <= sat_inc(flush_cnt_p1);
      else       bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else if (!en) begin
      // Stall: contents hold; only a held real instruction counts.
      if (vld_p1) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end else begin
      instr_p1   <= instr_i;
      pc_p1      <= pc_i;
      bd_p1      <= bd_i;
      vld_p1     <= 1'b1;
      exc_vld_p1 <= exc_vld_i;
      exc_p1     <= exc_vld_i ? exc_i : '0;
    end
  end

  assign instr_o    = instr_p1;
  assign imm_o      = instr_p1[15:0];
  assign pc_o       = pc_p1;
  assign bd_o       = bd_p1;
  assign valid_o    = vld_p1;
  assign exc_vld_o  = exc_vld_p1;
  assign exc_o      = exc_p1;
  assign stall_cnt  = stall_cnt_p1;
  assign bubble_cnt = bubble_cnt_p1;
  assign flush_cnt  = flush_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Three instances share one set of
//   inputs: the main one (non-zero NOP_VAL so reset and bubble values are
//   distinguishable), one with KEEP_PC=0 and one with 3-bit counters.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, en, clr, flush, bd_i, exc_vld_i;
  logic [31:0] instr_i, pc_i;
  logic [4:0]  exc_i;

  logic [31:0] instr_o, pc_o;
  logic [15:0] imm_o;
  logic        bd_o, valid_o, exc_vld_o;
  logic [4:0]  exc_o;
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;

  logic [31:0] k_instr_o, k_pc_o;
  logic [15:0] k_imm_o;
  logic        k_bd_o, k_valid_o, k_exc_vld_o;
  logic [4:0]  k_exc_o;
  logic [15:0] k_stall_cnt, k_bubble_cnt, k_flush_cnt;

  logic [31:0] c_instr_o, c_pc_o;
  logic [15:0] c_imm_o;
  logic        c_bd_o, c_valid_o, c_exc_vld_o;
  logic [4:0]  c_exc_o;
  logic [2:0]  c_stall_cnt, c_bubble_cnt, c_flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0020;

  always #5 clk = ~clk;

  pipe_stage_reg #(.NOP_VAL(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .flush(flush),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_vld_i(exc_vld_i), .exc_i(exc_i),
    .instr_o(instr_o), .imm_o(imm_o), .pc_o(pc_o), .bd_o(bd_o), .valid_o(valid_o),
    .exc_vld_o(exc_vld_o), .exc_o(exc_o),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));

  pipe_stage_reg #(.KEEP_PC(1'b0)) dut_k0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .flush(flush),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_vld_i(exc_vld_i), .exc_i(exc_i),
    .instr_o(k_instr_o), .imm_o(k_imm_o), .pc_o(k_pc_o), .bd_o(k_bd_o), .valid_o(k_valid_o),
    .exc_vld_o(k_exc_vld_o), .exc_o(k_exc_o),
    .stall_cnt(k_stall_cnt), .bubble_cnt(k_bubble_cnt), .flush_cnt(k_flush_cnt));

  pipe_stage_reg #(.CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .flush(flush),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_vld_i(exc_vld_i), .exc_i(exc_i),
    .instr_o(c_instr_o), .imm_o(c_imm_o), .pc_o(c_pc_o), .bd_o(c_bd_o), .valid_o(c_valid_o),
    .exc_vld_o(c_exc_vld_o), .exc_o(c_exc_o),
    .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt), .flush_cnt(c_flush_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; flush = 1'b0;
    instr_i = 32'h0; pc_i = 32'h0; bd_i = 1'b0; exc_vld_i = 1'b0; exc_i = 5'd0;
    step(2);
    chk("rst_instr",   instr_o, 32'h0);
    chk("rst_valid",   valid_o, 1'b0);
    chk("rst_pc",      pc_o, 32'h0);
    chk("rst_exc",     {exc_vld_o, exc_o}, 6'h0);
    chk("rst_cnts",    {stall_cnt, bubble_cnt, flush_cnt}, 48'h0);
    chk("rst_c3_cnts", {c_stall_cnt, c_bubble_cnt, c_flush_cnt}, 9'h0);

    // Basic load
    rst = 1'b0; en = 1'b1; instr_i = 32'h2408_000A; pc_i = 32'h0000_3008;
    step(1);
    chk("ld_instr", instr_o, 32'h2408_000A);
    chk("ld_imm",   imm_o, 16'h000A);
    chk("ld_pc",    pc_o, 32'h0000_3008);
    chk("ld_valid", valid_o, 1'b1);

    // Stall with a valid instruction, inputs changing underneath
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_i = 32'hDEAD_0000 + i;
      step(1);
    end
    chk("stall_instr", instr_o, 32'h2408_000A);
    chk("stall_cnt",   stall_cnt, 16'd3);
    chk("stall_c3",    c_stall_cnt, 3'd3);

    // Bubble
    en = 1'b1; clr = 1'b1; pc_i = 32'h0000_300C; bd_i = 1'b1;
    step(1);
    chk("bub_instr",   instr_o, NOP);
    chk("bub_valid",   valid_o, 1'b0);
    chk("bub_pc",      pc_o, 32'h0000_300C);
    chk("bub_bd",      bd_o, 1'b1);
    chk("bub_cnt",     bubble_cnt, 16'd1);
    chk("bub_k0_pc",   k_pc_o, 32'h0);
    chk("bub_k0_bd",   k_bd_o, 1'b0);
    chk("bub_k0_inst", k_instr_o, 32'h0);

    // Stall on a bubble: no stall count
    en = 1'b0; clr = 1'b0; bd_i = 1'b0;
    step(2);
    chk("stallbub_cnt",   stall_cnt, 16'd3);
    chk("stallbub_instr", instr_o, NOP);

    // Load an excepting instruction, then flush it during stall+clr
    en = 1'b1; instr_i = 32'h8C09_0004; pc_i = 32'h0000_3010;
    exc_vld_i = 1'b1; exc_i = 5'd12;
    step(1);
    chk("ldx_exc", {exc_vld_o, exc_o}, {1'b1, 5'd12});
    en = 1'b0; clr = 1'b1; flush = 1'b1; pc_i = 32'h0000_3014;
    step(1);
    chk("fl_exc",   {exc_vld_o, exc_o}, 6'h0);
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_instr", instr_o, NOP);
    chk("fl_pc",    pc_o, 32'h0000_3014);
    chk("fl_cnts",  {stall_cnt, bubble_cnt, flush_cnt}, {16'd3, 16'd1, 16'd1});

    // Exception code gating on load
    en = 1'b1; clr = 1'b0; flush = 1'b0;
    instr_i = 32'h0123_4567; exc_vld_i = 1'b1; exc_i = 5'd10;
    step(1);
    chk("exc10",     {exc_vld_o, exc_o}, {1'b1, 5'd10});
    chk("exc10_ins", instr_o, 32'h0123_4567);
    exc_vld_i = 1'b0;
    step(1);
    chk("exc_clr",   {valid_o, exc_vld_o, exc_o}, {1'b1, 1'b0, 5'd0});

    // Bubble counter saturation on the 3-bit instance (already holds 1)
    clr = 1'b1;
    step(5);
    chk("sat_mid",  c_bubble_cnt, 3'd6);
    step(4);
    chk("sat_c3",   c_bubble_cnt, 3'd7);
    chk("sat_main", bubble_cnt, 16'd10);

    // Reset in the middle of a flush/bubble burst
    flush = 1'b1; rst = 1'b1;
    step(1);
    chk("mrst_cnts",  {stall_cnt, bubble_cnt, flush_cnt}, 48'h0);
    chk("mrst_c3",    {c_stall_cnt, c_bubble_cnt, c_flush_cnt}, 9'h0);
    chk("mrst_instr", instr_o, 32'h0);

    // Runs normally from reset state
    rst = 1'b0; flush = 1'b0; clr = 1'b0;
    instr_i = 32'h3C01_FFFF; pc_i = 32'h0000_3018;
    step(1);
    chk("post_imm",   imm_o, 16'hFFFF);
    chk("post_valid", valid_o, 1'b1);

    // Flush with en=1 and clr=1 counts only as a flush
    flush = 1'b1; clr = 1'b1;
    step(1);
    chk("fl2_cnts", {stall_cnt, bubble_cnt, flush_cnt}, {16'd0, 16'd0, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
